some_vip_arbiter: RTL and testbench

Round-robin arbiter that shares the single some_vip valid/ready/8-bit data channel of the DUT (the `valid_i`/`data_i`/`ready_o` side) between `N_REQ` upstream requesters. It sits directly in front of the DUT. Each granted requester may stream up to `MAX_BURST` consecutive beats before the grant rotates. Every forwarded beat passes through one registered output stage, and the stage tags each beat with its source index.

---
 rtl/some_vip_arb_pkg.sv | 24 ++
 rtl/some_vip_arbiter_rr_picker.sv | 40 ++++
 rtl/some_vip_arbiter.sv | 152 +++++++++++++++
 tb/tb_some_vip_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/some_vip_arb_pkg.sv
// ---------------------------------------------------------------------------
// some_vip_arb_pkg
// Shared types and defaults for the some_vip round-robin arbiter.
//   arb_state_t   : arbiter FSM state (IDLE / GRANT)
//   *_DEF         : default parameter values for the top level
//   wrap_inc()    : modulo-n increment used to form the round-robin start index
// ---------------------------------------------------------------------------
package some_vip_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int N_REQ_DEF     = 4;
  localparam int DATA_W_DEF    = 8;
  localparam int MAX_BURST_DEF = 4;

  // (v + 1) mod n, for 0 <= v < n.
  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/some_vip_arbiter_rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
// Combinational round-robin search: starting at start_i and wrapping modulo
// N, return the first index whose request bit is set.
//   req_i   in  N       : request vector
//   start_i in  IW      : first index to examine (must be < N)
//   found_o out 1       : at least one request bit is set
//   idx_o   out IW      : winning index (0 when nothing found)
// ---------------------------------------------------------------------------
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] start_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);

  int j;

  // Walk the offsets from farthest to nearest so the nearest requester to
  // start_i is the last assignment and therefore the winner.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    j       = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(start_i) + k;
      if (j >= N) begin
        j = j - N;
      end
      if (req_i[j]) begin
        found_o = 1'b1;
        idx_o   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/some_vip_arbiter.sv
// ---------------------------------------------------------------------------
// some_vip_arbiter
// Round-robin arbiter sharing one valid/ready data channel between N_REQ
// requesters. A granted requester streams up to MAX_BURST beats before the
// grant rotates. Each forwarded beat goes through one registered output stage
// that also records the source index.
//   clk          in  1            : clock, rising edge
//   rst_n        in  1            : asynchronous active-low reset
//   req_valid_i  in  N_REQ        : per-requester beat valid
//   req_data_i   in  N_REQ*DATA_W : requester i at [i*DATA_W +: DATA_W]
//   req_ready_o  out N_REQ        : per-requester beat accepted (combinational)
//   m_valid_o    out 1            : downstream valid
//   m_data_o     out DATA_W       : downstream data
//   m_ready_i    in  1            : downstream ready
//   m_src_o      out IW           : source index of m_data_o
// ---------------------------------------------------------------------------
module some_vip_arbiter
  import some_vip_arb_pkg::*;
#(
  parameter int N_REQ     = N_REQ_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF,
  parameter int IW        = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid_i,
  input  logic [N_REQ*DATA_W-1:0] req_data_i,
  output logic [N_REQ-1:0]        req_ready_o,
  output logic                    m_valid_o,
  output logic [DATA_W-1:0]       m_data_o,
  input  logic                    m_ready_i,
  output logic [IW-1:0]           m_src_o
);

  localparam int BW = $clog2(MAX_BURST + 1);

  arb_state_t        state_q, state_d;
  // last_q is the round-robin pointer. Because it is updated to the winner on
  // every grant, it also names the current owner while in GRANT.
  logic [IW-1:0]     last_q, last_d;
  logic [BW-1:0]     burst_q, burst_d;
  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [IW-1:0]     m_src_q, m_src_d;

  logic              granted;
  logic              can_accept;
  logic              owner_valid;
  logic              load;
  logic              release_grant;
  logic [BW-1:0]     burst_inc;
  logic [IW-1:0]     pick_start;
  logic              pick_found;
  logic [IW-1:0]     pick_idx;

  assign granted     = (state_q == GRANT);
  // Output stage can take a beat when empty or draining this same cycle.
  assign can_accept  = !m_valid_q || m_ready_i;
  assign owner_valid = req_valid_i[last_q];
  assign load        = granted && owner_valid && can_accept;
  assign burst_inc   = burst_q + 1'b1;

  // Release either on hitting the burst limit with this load, or when the
  // owner has nothing to offer in a cycle it could have been accepted.
  assign release_grant = granted && can_accept &&
                         (!owner_valid || (burst_inc == BW'(MAX_BURST)));

  // In IDLE the scan starts after the last winner; on release last_q equals
  // the owner, so the same start index gives "owner eligible, but last".
  assign pick_start = IW'(wrap_inc(int'(last_q), N_REQ));

  rr_picker #(
    .N  (N_REQ),
    .IW (IW)
  ) u_picker (
    .req_i   (req_valid_i),
    .start_i (pick_start),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
      assign req_ready_o[gi] = granted && can_accept && (last_q == IW'(gi));
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    burst_d   = burst_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_src_d   = m_src_q;

    if (load) begin
      m_valid_d = 1'b1;
      m_data_d  = req_data_i[int'(last_q)*DATA_W +: DATA_W];
      m_src_d   = last_q;
      burst_d   = burst_inc;
    end else if (m_valid_q && m_ready_i) begin
      m_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = GRANT;
          last_d  = pick_idx;
          burst_d = '0;
        end
      end
      GRANT: begin
        if (release_grant) begin
          burst_d = '0;
          if (pick_found) begin
            last_d = pick_idx;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      last_q    <= IW'(N_REQ - 1);
      burst_q   <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_src_q   <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      burst_q   <= burst_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_src_q   <= m_src_d;
    end
  end

  assign m_valid_o = m_valid_q;
  assign m_data_o  = m_data_q;
  assign m_src_o   = m_src_q;

endmodule

// File: tb/tb_some_vip_arbiter.sv
// ---------------------------------------------------------------------------
// tb_some_vip_arbiter
// Directed bench for some_vip_arbiter. Main instance uses MAX_BURST=4; a
// second instance with MAX_BURST=1 is held under full contention.
// Expected beats go into a queue as stimulus is issued; a monitor pops and
// compares every beat the arbiter hands downstream.
// ---------------------------------------------------------------------------
module tb_some_vip_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // main instance
  logic [N-1:0]   req_valid_i;
  logic [N*W-1:0] req_data_i;
  logic [N-1:0]   req_ready_o;
  logic           m_valid_o;
  logic [W-1:0]   m_data_o;
  logic           m_ready_i;
  logic [IW-1:0]  m_src_o;

  // contention instance
  logic [N-1:0]   b_valid;
  logic [N*W-1:0] b_data;
  logic [N-1:0]   b_ready;
  logic           b_m_valid;
  logic [W-1:0]   b_m_data;
  logic [IW-1:0]  b_m_src;

  some_vip_arbiter #(.N_REQ(N), .DATA_W(W), .MAX_BURST(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_i (req_valid_i),
    .req_data_i  (req_data_i),
    .req_ready_o (req_ready_o),
    .m_valid_o   (m_valid_o),
    .m_data_o    (m_data_o),
    .m_ready_i   (m_ready_i),
    .m_src_o     (m_src_o)
  );

  some_vip_arbiter #(.N_REQ(N), .DATA_W(W), .MAX_BURST(1)) dut_b1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_i (b_valid),
    .req_data_i  (b_data),
    .req_ready_o (b_ready),
    .m_valid_o   (b_m_valid),
    .m_data_o    (b_m_data),
    .m_ready_i   (1'b1),
    .m_src_o     (b_m_src)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // ---------------- requester drivers (valid/data held until ready) -------
  logic [W-1:0] beat_mem [N][64];
  int           head [N];
  int           tail [N];
  logic [N-1:0] acc;

  task automatic push_beat(input int r, input logic [W-1:0] d);
    beat_mem[r][tail[r] % 64] = d;
    tail[r]++;
  endtask

  initial begin
    req_valid_i = '0;
    req_data_i  = '0;
    acc         = '0;
    for (int i = 0; i < N; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    forever begin
      @(negedge clk);
      acc = req_valid_i & req_ready_o;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i]) head[i]++;
        if (head[i] < tail[i]) begin
          req_valid_i[i]       = 1'b1;
          req_data_i[i*W +: W] = beat_mem[i][head[i] % 64];
        end else begin
          req_valid_i[i]       = 1'b0;
          req_data_i[i*W +: W] = '0;
        end
      end
    end
  end

  // ---------------- scoreboard + monitors ----------------------------------
  logic [31:0] exp_q [$];
  logic [31:0] exp_b [$];
  int          pops_b = 0;

  task automatic expect_beat(input int src, input logic [W-1:0] d);
    exp_q.push_back(32'((src << 8) | int'(d)));
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && m_valid_o && m_ready_i) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_beat", 32'({m_src_o, m_data_o}), 32'hFFFF_FFFF);
        end else begin
          chk("sb_beat", 32'({m_src_o, m_data_o}), exp_q.pop_front());
        end
      end
    end
  end

  // Once the contention stream starts, every cycle must carry a beat.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_b.size() > 0 && (b_m_valid || pops_b > 0)) begin
        chk("b1_no_bubble", 32'(b_m_valid), 32'd1);
        if (b_m_valid) begin
          chk("b1_src", 32'({b_m_src, b_m_data}), exp_b.pop_front());
          pops_b++;
        end
      end
    end
  end

  task automatic wait_drain(input string name);
    logic busy;
    busy = 1'b1;
    for (int k = 0; k < 200 && busy; k++) begin
      @(negedge clk);
      busy = (exp_q.size() != 0) || m_valid_o || (req_valid_i != '0);
    end
    chk(name, 32'(busy), 32'd0);
  endtask

  // ---------------- directed sequence --------------------------------------
  initial begin
    logic seen;
    m_ready_i = 1'b1;
    b_valid   = '0;
    b_data    = {8'hB3, 8'hB2, 8'hB1, 8'hB0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m_valid", 32'(m_valid_o), 32'd0);
    chk("rst_m_data", 32'(m_data_o), 32'd0);
    chk("rst_m_src", 32'(m_src_o), 32'd0);
    chk("rst_req_ready", 32'(req_ready_o), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Full contention, MAX_BURST=1: sources 0,1,2,3,0,1 back to back.
    exp_b.push_back(32'h0B0);
    exp_b.push_back(32'h1B1);
    exp_b.push_back(32'h2B2);
    exp_b.push_back(32'h3B3);
    exp_b.push_back(32'h0B0);
    exp_b.push_back(32'h1B1);
    @(posedge clk);
    #1 b_valid = '1;
    for (int k = 0; k < 50 && exp_b.size() > 0; k++) @(posedge clk);
    chk("b1_done", 32'(exp_b.size()), 32'd0);
    #1 b_valid = '0;

    // Single requester: req1 sends 0x11, 0x22.
    @(negedge clk);
    push_beat(1, 8'h11);
    push_beat(1, 8'h22);
    expect_beat(1, 8'h11);
    expect_beat(1, 8'h22);
    @(negedge clk);
    chk("t1_ready_valid_cycle", 32'(req_ready_o), 32'h0);
    @(negedge clk);
    chk("t1_ready_next_cycle", 32'(req_ready_o), 32'h2);
    @(negedge clk);
    chk("t1_beat0", 32'({m_valid_o, m_src_o, m_data_o}), 32'h511);
    @(negedge clk);
    chk("t1_beat1", 32'({m_valid_o, m_src_o, m_data_o}), 32'h522);
    wait_drain("t1_drain");

    // Backpressure: 0xA5 held for 5 cycles, then 0xB6 follows.
    m_ready_i = 1'b0;
    push_beat(2, 8'hA5);
    push_beat(2, 8'hB6);
    expect_beat(2, 8'hA5);
    expect_beat(2, 8'hB6);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      seen = m_valid_o;
    end
    chk("bp_first_valid", 32'(seen), 32'd1);
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      chk("bp_hold_out", 32'({m_valid_o, m_src_o, m_data_o}), 32'h6A5);
      chk("bp_hold_ready", 32'(req_ready_o), 32'h0);
    end
    @(posedge clk);
    #1 m_ready_i = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 32'(req_ready_o), 32'h4);
    @(negedge clk);
    chk("bp_next_beat", 32'({m_valid_o, m_src_o, m_data_o}), 32'h6B6);
    wait_drain("bp_drain");

    // Burst limit: req0 and req2 alternate in groups of 4.
    for (int i = 0; i < 8; i++) begin
      push_beat(0, 8'(8'h01 + i));
      push_beat(2, 8'(8'h21 + i));
    end
    for (int grp = 0; grp < 4; grp++) begin
      for (int i = 0; i < 4; i++) begin
        if (grp % 2 == 0) expect_beat(0, 8'(8'h01 + (grp / 2) * 4 + i));
        else              expect_beat(2, 8'(8'h21 + (grp / 2) * 4 + i));
      end
    end
    wait_drain("burst_drain");

    // Early release: req3 stops after 2 beats; req0 then gets a fresh burst
    // of 4 before req1 is served.
    push_beat(3, 8'h31);
    push_beat(3, 8'h32);
    for (int i = 0; i < 5; i++) push_beat(0, 8'(8'h0A + i));
    push_beat(1, 8'h1F);
    expect_beat(3, 8'h31);
    expect_beat(3, 8'h32);
    for (int i = 0; i < 4; i++) expect_beat(0, 8'(8'h0A + i));
    expect_beat(1, 8'h1F);
    expect_beat(0, 8'h0E);
    wait_drain("early_drain");

    // Reset mid-burst: req2 owns the channel when rst_n falls.
    for (int i = 0; i < 4; i++) begin
      push_beat(2, 8'(8'h71 + i));
      expect_beat(2, 8'(8'h71 + i));
    end
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      seen = m_valid_o;
    end
    chk("rstmid_busy", 32'(seen), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_m_valid", 32'(m_valid_o), 32'd0);
    chk("rstmid_m_data", 32'(m_data_o), 32'd0);
    chk("rstmid_m_src", 32'(m_src_o), 32'd0);
    chk("rstmid_req_ready", 32'(req_ready_o), 32'd0);
    exp_q.delete();
    acc = '0;
    for (int i = 0; i < N; i++) head[i] = tail[i];
    push_beat(2, 8'h66);
    push_beat(0, 8'h55);
    expect_beat(0, 8'h55);
    expect_beat(2, 8'h66);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_drain("rstmid_drain");

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
